// File: rtl/vga_video_sync_generator.sv
// Free-running VGA raster timing generator: registered active-low HS/VS and blank_n.
// Define VSG_PIXEL_COORD_EN to also produce registered active-area pixel_x/pixel_y.
module vga_video_sync_generator #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    output logic       blank_n,
    output logic       HS,
    output logic       VS,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_MAX     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_START   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_STOP    = 10'(H_TOTAL - H_FRONT);
    localparam logic [9:0] V_START   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_STOP    = 10'(V_TOTAL - V_FRONT);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_valid;
    logic       v_valid;
    logic       active;

    always_comb begin
        h_wrap  = (h_cnt == H_MAX);
        v_wrap  = (v_cnt == V_MAX);
        h_valid = (h_cnt >= H_START) && (h_cnt < H_STOP);
        v_valid = (v_cnt >= V_START) && (v_cnt < V_STOP);
        active  = h_valid && v_valid;
    end

    // Wraps are explicit compares so non-power-of-two totals never rely on overflow.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            HS      <= 1'b1;
            VS      <= 1'b1;
            blank_n <= 1'b0;
        end else begin
            HS      <= (h_cnt >= H_SYNC_END);
            VS      <= (v_cnt >= V_SYNC_END);
            blank_n <= active;
        end
    end

`ifdef VSG_PIXEL_COORD_EN
    // Coordinates are registered alongside blank_n and parked at 0 during blanking.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (active) begin
            pixel_x <= h_cnt - H_START;
            pixel_y <= v_cnt - V_START;
        end else begin
            pixel_x <= '0;
            pixel_y <= '0;
        end
    end
`else
    assign pixel_x = '0;
    assign pixel_y = '0;
`endif

endmodule

// File: tb/tb_vga_video_sync_generator.sv
// Directed bench: default 640x480 instance for line/sync/first-active timing, plus a
// small-raster instance (13x10 clocks) for whole-frame totals and mid-frame reset.
module tb_vga_video_sync_generator;

`ifdef VSG_PIXEL_COORD_EN
    localparam bit COORD = 1'b1;
`else
    localparam bit COORD = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rst_s_n;
    logic       blank_n, hs, vs;
    logic [9:0] px, py;
    logic       blank_s, hs_s, vs_s;
    logic [9:0] px_s, py_s;

    int total;
    int bad;

    vga_video_sync_generator dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .blank_n  (blank_n),
        .HS       (hs),
        .VS       (vs),
        .pixel_x  (px),
        .pixel_y  (py)
    );

    // Small raster: H = 3+2+6+2 = 13, V = 2+2+5+1 = 10, frame = 130 clocks.
    vga_video_sync_generator #(
        .H_SYNC   (3),
        .H_BACK   (2),
        .H_ACTIVE (6),
        .H_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (2),
        .V_ACTIVE (5),
        .V_FRONT  (1)
    ) dut_s (
        .iVGA_CLK (clk),
        .iRST_n   (rst_s_n),
        .blank_n  (blank_s),
        .HS       (hs_s),
        .VS       (vs_s),
        .pixel_x  (px_s),
        .pixel_y  (py_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_big();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reset_small();
        rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_s_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({hs, vs, blank_n} !== 3'b110) begin
                bad++;
                $display("FAIL reset_big_out cyc=%0d got=%b want=110", i, {hs, vs, blank_n});
            end
            total++;
            if ({hs_s, vs_s, blank_s} !== 3'b110) begin
                bad++;
                $display("FAIL reset_small_out cyc=%0d got=%b want=110", i, {hs_s, vs_s, blank_s});
            end
        end
        total++;
        if ({px, py} !== 20'd0) begin
            bad++;
            $display("FAIL reset_coord got=%0d/%0d want=0/0", px, py);
        end
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        @(negedge clk);
        total++;
        if ({hs, vs, blank_n} !== 3'b000) begin
            bad++;
            $display("FAIL release_big_out got=%b want=000", {hs, vs, blank_n});
        end
        total++;
        if ({hs_s, vs_s, blank_s} !== 3'b000) begin
            bad++;
            $display("FAIL release_small_out got=%b want=000", {hs_s, vs_s, blank_s});
        end
    endtask

    task automatic test_hsync();
        int low;
        int rise;
        logic first;
        reset_big();
        for (int line = 0; line < 3; line++) begin
            low  = 0;
            rise = -1;
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                if (i == 0) first = hs;
                if (hs === 1'b0) low++;
                else if (rise < 0) rise = i;
            end
            total++;
            if (first !== 1'b0) begin
                bad++;
                $display("FAIL hs_line_start line=%0d got=%b want=0", line, first);
            end
            total++;
            if (low != 96) begin
                bad++;
                $display("FAIL hs_low_width line=%0d got=%0d want=96", line, low);
            end
            total++;
            if (800 - low != 704 || rise != 96) begin
                bad++;
                $display("FAIL hs_high line=%0d rise=%0d high=%0d want rise=96 high=704",
                         line, rise, 800 - low);
            end
        end
    endtask

    task automatic test_vsync();
        int low;
        int last_low;
        reset_big();
        low      = 0;
        last_low = -1;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if ((hs | vs) !== 1'b0) begin
                    bad++;
                    $display("FAIL frame_start_syncs got hs=%b vs=%b want 0/0", hs, vs);
                end
            end
            if (vs === 1'b0) begin
                low++;
                last_low = i;
            end
        end
        total++;
        if (low != 1600) begin
            bad++;
            $display("FAIL vs_low_width got=%0d want=1600", low);
        end
        total++;
        if (last_low != 1599) begin
            bad++;
            $display("FAIL vs_last_low got=%0d want=1599", last_low);
        end
    endtask

    task automatic test_first_active();
        int n;
        int run;
        reset_big();
        n = 0;
        while (blank_n !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 35 * 800 + 144 + 1) begin
            bad++;
            $display("FAIL first_blank_rise got=%0d want=%0d", n, 35 * 800 + 144 + 1);
        end
        total++;
        if ({px, py} !== 20'd0) begin
            bad++;
            $display("FAIL first_pixel_coord got=%0d/%0d want=0/0", px, py);
        end
        run = 0;
        while (blank_n === 1'b1 && run < 1000) begin
            run++;
            @(negedge clk);
        end
        total++;
        if (run != 640) begin
            bad++;
            $display("FAIL active_run got=%0d want=640", run);
        end
    endtask

    task automatic test_frame_small();
        int hi;
        int vlow;
        int first_b;
        logic [9:0] last_x, last_y, or_xy;
        reset_small();
        for (int f = 0; f < 2; f++) begin
            hi      = 0;
            vlow    = 0;
            first_b = -1;
            last_x  = '1;
            last_y  = '1;
            or_xy   = '0;
            for (int i = 0; i < 130; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    total++;
                    if ({hs_s, vs_s} !== 2'b00) begin
                        bad++;
                        $display("FAIL small_frame_start f=%0d got=%b want=00", f, {hs_s, vs_s});
                    end
                end
                if (vs_s === 1'b0) vlow++;
                or_xy = or_xy | px_s | py_s;
                if (blank_s === 1'b1) begin
                    hi++;
                    if (first_b < 0) first_b = i;
                    last_x = px_s;
                    last_y = py_s;
                end
            end
            total++;
            if (hi != 30) begin
                bad++;
                $display("FAIL small_blank_total f=%0d got=%0d want=30", f, hi);
            end
            total++;
            if (vlow != 26) begin
                bad++;
                $display("FAIL small_vs_low f=%0d got=%0d want=26", f, vlow);
            end
            total++;
            if (first_b != 57) begin
                bad++;
                $display("FAIL small_first_active f=%0d got=%0d want=57", f, first_b);
            end
            total++;
            if (last_x !== (COORD ? 10'd5 : 10'd0) || last_y !== (COORD ? 10'd4 : 10'd0)) begin
                bad++;
                $display("FAIL small_last_coord f=%0d got=%0d/%0d want=%0d/%0d", f,
                         last_x, last_y, COORD ? 5 : 0, COORD ? 4 : 0);
            end
            if (!COORD) begin
                total++;
                if (or_xy !== 10'd0) begin
                    bad++;
                    $display("FAIL coord_tied_zero f=%0d got=%0h want=0", f, or_xy);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int n;
        reset_small();
        repeat (72) @(negedge clk);
        // Sample 72 shows counter (h=6, v=5): active pixel, both syncs high.
        total++;
        if ({hs_s, vs_s, blank_s} !== 3'b111) begin
            bad++;
            $display("FAIL pre_reset_state got=%b want=111", {hs_s, vs_s, blank_s});
        end
        total++;
        if (px_s !== (COORD ? 10'd1 : 10'd0) || py_s !== (COORD ? 10'd1 : 10'd0)) begin
            bad++;
            $display("FAIL pre_reset_coord got=%0d/%0d want=%0d/%0d", px_s, py_s,
                     COORD ? 1 : 0, COORD ? 1 : 0);
        end
        rst_s_n = 1'b0;
        @(negedge clk);
        total++;
        if ({hs_s, vs_s, blank_s} !== 3'b110 || {px_s, py_s} !== 20'd0) begin
            bad++;
            $display("FAIL midframe_reset got=%b coord=%0d/%0d want=110 0/0",
                     {hs_s, vs_s, blank_s}, px_s, py_s);
        end
        @(negedge clk);
        rst_s_n = 1'b1;
        @(negedge clk);
        total++;
        if ({hs_s, vs_s, blank_s} !== 3'b000) begin
            bad++;
            $display("FAIL restart_first got=%b want=000", {hs_s, vs_s, blank_s});
        end
        n = 1;
        while (blank_s !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 58) begin
            bad++;
            $display("FAIL restart_first_active got=%0d want=58", n);
        end
        total++;
        if ({px_s, py_s} !== 20'd0) begin
            bad++;
            $display("FAIL restart_coord got=%0d/%0d want=0/0", px_s, py_s);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        test_reset();
        test_hsync();
        test_vsync();
        test_first_active();
        test_frame_small();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
